// File: rtl/freq_meter.sv
// Gated frequency meter: counts synchronized rising edges of sig_i over a window of
// GATE_CYCLES clocks and publishes the count with a one-cycle valid strobe.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 100_000_000,
  parameter int unsigned GATE_W      = 27,
  parameter int unsigned CNT_W       = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             sig_i,
  output logic [CNT_W-1:0] freq_o,
  output logic             valid_o,
  output logic             ovf_o,
  output logic             busy_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_GATE = 2'd2;

  localparam logic [GATE_W-1:0] GateLast = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CntMax   = '1;

  logic              sync1_q, sync2_q, prev_q;
  logic [1:0]        state_q, state_d;
  logic [1:0]        armCnt_q, armCnt_d;
  logic [GATE_W-1:0] gateCnt_q, gateCnt_d;
  logic [CNT_W-1:0]  edgeCnt_q, edgeCnt_d;
  logic              sat_q, sat_d;
  logic [CNT_W-1:0]  freq_q, freq_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;

  logic              rise;
  logic [CNT_W-1:0]  edgeNext;
  logic              satNext;

  assign rise = sync2_q & ~prev_q;

  // The synchronizer keeps running in IDLE and ARM so a static high level never looks like an edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sig_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_comb begin
    edgeNext = edgeCnt_q;
    satNext  = sat_q;
    if (rise) begin
      if (edgeCnt_q == CntMax) begin
        satNext = 1'b1;
      end else begin
        edgeNext = edgeCnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    armCnt_d  = armCnt_q;
    gateCnt_d = gateCnt_q;
    edgeCnt_d = edgeCnt_q;
    sat_d     = sat_q;
    freq_d    = freq_q;
    ovf_d     = ovf_q;
    valid_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        armCnt_d  = 2'd0;
        gateCnt_d = '0;
        edgeCnt_d = '0;
        sat_d     = 1'b0;
        if (en_i) begin
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        gateCnt_d = '0;
        edgeCnt_d = '0;
        sat_d     = 1'b0;
        if (!en_i) begin
          state_d = S_IDLE;
        end else if (armCnt_q == 2'd2) begin
          armCnt_d = 2'd0;
          state_d  = S_GATE;
        end else begin
          armCnt_d = armCnt_q + 2'd1;
        end
      end
      S_GATE: begin
        // Disable wins over a terminal cycle: the partial window is simply dropped.
        if (!en_i) begin
          state_d = S_IDLE;
        end else if (gateCnt_q == GateLast) begin
          freq_d    = edgeNext;
          ovf_d     = satNext;
          valid_d   = 1'b1;
          gateCnt_d = '0;
          edgeCnt_d = '0;
          sat_d     = 1'b0;
        end else begin
          gateCnt_d = gateCnt_q + GATE_W'(1);
          edgeCnt_d = edgeNext;
          sat_d     = satNext;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      armCnt_q  <= 2'd0;
      gateCnt_q <= '0;
      edgeCnt_q <= '0;
      sat_q     <= 1'b0;
      freq_q    <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      armCnt_q  <= armCnt_d;
      gateCnt_q <= gateCnt_d;
      edgeCnt_q <= edgeCnt_d;
      sat_q     <= sat_d;
      freq_q    <= freq_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
    end
  end

  assign freq_o  = freq_q;
  assign valid_o = valid_q;
  assign ovf_o   = ovf_q;
  assign busy_o  = busy_q;

endmodule
